dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and a

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_sram.sv | 57 +++++
 rtl/dcache_ctrl.sv | 109 ++++++++++
 tb/tb_dcache_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and line word helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

  localparam int ADDR_W     = 32;
  localparam int NUM_LINES  = 32;
  localparam int LINE_BYTES = 32;
  localparam int INDEX_W    = $clog2(NUM_LINES);
  localparam int OFFSET_W   = $clog2(LINE_BYTES);
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int WORD_SEL_W = OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  // Word w of a line occupies bits [32*w +: 32], i.e. byte offset 4*w.
  function automatic logic [31:0] word_select(input logic [LINE_W-1:0]     line,
                                              input logic [WORD_SEL_W-1:0] sel);
    return line[sel*32 +: 32];
  endfunction

  function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0]     line,
                                                   input logic [WORD_SEL_W-1:0] sel,
                                                   input logic [31:0]           data);
    logic [LINE_W-1:0] merged;
    merged = line;
    merged[sel*32 +: 32] = data;
    return merged;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag, valid, dirty and data storage for the cache: one combinational read port
// and one synchronous write port (line fill, word merge, or dirty clear).
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_W-1:0]     rd_line,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic                  fill_we,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic [LINE_W-1:0]     fill_line,
  input  logic                  word_we,
  input  logic [WORD_SEL_W-1:0] word_sel,
  input  logic [31:0]           word_data,
  input  logic                  clean_we
);

  logic [TAG_W-1:0]  tag_mem  [NUM_LINES];
  logic [LINE_W-1:0] data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;

  assign rd_valid = valid_reg[rd_index];
  assign rd_dirty = dirty_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

  // Only the status bits are reset; stale tags are harmless while valid is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (fill_we) begin
      valid_reg[wr_index] <= 1'b1;
      dirty_reg[wr_index] <= 1'b0;
    end else if (word_we) begin
      dirty_reg[wr_index] <= 1'b1;
    end else if (clean_we) begin
      dirty_reg[wr_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_mem[wr_index]  <= fill_tag;
      data_mem[wr_index] <= fill_line;
    end else if (word_we) begin
      data_mem[wr_index] <= word_merge(data_mem[wr_index], word_sel, word_data);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate L1 data cache controller: hit logic,
// pipeline stall, and the writeback/refill FSM toward a multi-cycle memory.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_t state_reg, state_next;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_index;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  line_valid, line_dirty, hit;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;
  logic                  fill_we, word_we, clean_we;
  logic                  unused_addr_bits;

  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_index        = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_word         = cpu_addr_i[2 +: WORD_SEL_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_index  (req_index),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_line   (line_data),
    .wr_index  (req_index),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_line (mem_rdata_i),
    .word_we   (word_we),
    .word_sel  (req_word),
    .word_data (cpu_wdata_i),
    .clean_we  (clean_we)
  );

  assign hit = cpu_req_i & line_valid & (line_tag == req_tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    cpu_stall_o = 1'b0;
    cpu_rdata_o = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    fill_we     = 1'b0;
    word_we     = 1'b0;
    clean_we    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          if (cpu_we_i) word_we = 1'b1;
          else          cpu_rdata_o = word_select(line_data, req_word);
        end else if (cpu_req_i) begin
          cpu_stall_o = 1'b1;
          state_next  = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {line_tag, req_index, {OFFSET_W{1'b0}}};
        mem_wdata_o = line_data;
        if (mem_ack_i) begin
          clean_we   = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
        // Refill installs the line even if the request was withdrawn meanwhile.
        if (mem_ack_i) begin
          fill_we    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: flat-memory reference model, policy-level
// cache model for stall/traffic expectations, and a latency-configurable memory.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o, mem_rdata_i;

  logic         resp_ack, idle_ack;
  logic [255:0] resp_data;
  int           lat_cfg;
  int           n_cmp = 0;
  int           n_err = 0;
  int           first_stall;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] wdata;
  } txn_t;

  txn_t        txn_log[$];
  logic [31:0] exp_q[$];
  logic [31:0]  ref_mem [logic [31:0]];
  logic [255:0] backing [logic [31:0]];
  logic [21:0]  m_tag   [32];
  bit           m_valid [32];
  bit           m_dirty [32];

  assign mem_ack_i   = resp_ack | idle_ack;
  assign mem_rdata_i = idle_ack ? {8{32'hBAD0_BAD0}} : resp_data;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h48) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] line_get(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(la + 32'(w * 4));
    return l;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: ack lat_cfg cycles after a request first appears, abort if dropped.
  initial begin
    int  k;
    bit  alive;
    resp_ack  = 1'b0;
    resp_data = '0;
    forever begin
      @(posedge clk); #1;
      resp_ack = 1'b0;
      if (mem_req_o && !rst_i) begin
        k = 1;
        alive = 1'b1;
        while (k < lat_cfg) begin
          @(posedge clk); #1;
          k++;
          if (!mem_req_o) begin
            alive = 1'b0;
            break;
          end
        end
        if (alive) begin
          if (mem_we_o) backing[mem_addr_o] = mem_wdata_o;
          else          resp_data = line_get(mem_addr_o);
          txn_log.push_back('{mem_we_o, mem_addr_o, mem_wdata_o});
          resp_ack = 1'b1;
        end
      end
    end
  end

  // Monitor: every accepted load is compared against the scoreboard queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_i && cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
        if (exp_q.size() == 0) begin
          check32("unexpected_load", cpu_rdata_o, 32'hx);
        end else begin
          e = exp_q.pop_front();
          check32("load_data", cpu_rdata_o, e);
        end
      end
    end
  end

  task automatic do_access(input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, output int stalls);
    logic [31:0] a;
    logic [4:0]  idx;
    logic [21:0] tg;
    bit          m_hit;
    int          exp_txn;
    a     = {addr[31:2], 2'b00};
    idx   = a[9:5];
    tg    = a[31:10];
    m_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_txn = m_hit ? 0 : ((m_valid[idx] && m_dirty[idx]) ? 2 : 1);
    if (!we) exp_q.push_back(ref_get(a));
    txn_log.delete();
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    stalls = 0;
    first_stall = -1;
    forever begin
      @(negedge clk);
      if (first_stall < 0) first_stall = int'(cpu_stall_o);
      if (!cpu_stall_o) break;
      stalls++;
      if (stalls > 200) begin
        check32("access_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
    if (we) ref_mem[a] = wd;
    check32("txn_count", 32'(txn_log.size()), 32'(exp_txn));
    check32("stall_cycles", 32'(stalls), 32'(m_hit ? 0 : 1 + lat_cfg * exp_txn));
    if (txn_log.size() > 0)
      check32("refill_addr", txn_log[txn_log.size()-1].addr, {a[31:5], 5'b0});
    if (exp_txn == 2)
      check32("wb_addr", txn_log[0].addr, {m_tag[idx], idx, 5'b0});
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tg;
    if (!m_hit) m_dirty[idx] = 1'b0;
    if (we) m_dirty[idx] = 1'b1;
    $display("access we=%0d addr=%h stalls=%0d txns=%0d", we, addr, stalls, txn_log.size());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [31:0] ra, rw;
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = '0; cpu_wdata_i = '0; idle_ack = 1'b0; lat_cfg = 3;
    for (int i = 0; i < 32; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check32("rst_stall", 32'(cpu_stall_o), 32'd0);
    check32("rst_mem_req", 32'(mem_req_o), 32'd0);
    check32("rst_mem_we", 32'(mem_we_o), 32'd0);
    check32("rst_rdata", cpu_rdata_o, 32'd0);
    check32("rst_mem_addr", mem_addr_o, 32'd0);

    // Cold miss and refill, then hit on the refilled line.
    do_access(1'b0, 32'h40, 32'h0, s);
    check32("t1_first_stall", 32'(first_stall), 32'd1);
    check32("t1_refill_we", 32'(txn_log.size() > 0 ? txn_log[0].we : 1'b1), 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    ref_mem[32'h48] = 32'hDEAD_BEEF;
    void'(exp_q.pop_back());
    do_access(1'b0, 32'h48, 32'h0, s);
    check32("t1_hit_stall", 32'(s), 32'd0);

    // Store hit then load hit.
    do_access(1'b1, 32'h44, 32'h1234_5678, s);
    check32("t2_store_stall", 32'(s), 32'd0);
    do_access(1'b0, 32'h44, 32'h0, s);
    check32("t2_load_stall", 32'(s), 32'd0);

    // Dirty victim: writeback then refill.
    lat_cfg = 2;
    do_access(1'b0, 32'h440, 32'h0, s);
    if (txn_log.size() == 2) begin
      check32("t3_wb_we", 32'(txn_log[0].we), 32'd1);
      check32("t3_wb_addr", txn_log[0].addr, 32'h40);
      check32("t3_wb_word1", txn_log[0].wdata[63:32], 32'h1234_5678);
      check32("t3_wb_word2", txn_log[0].wdata[95:64], 32'hDEAD_BEEF);
      check32("t3_rf_addr", txn_log[1].addr, 32'h440);
    end

    // Clean victim, 5-cycle ack latency.
    lat_cfg = 5;
    do_access(1'b0, 32'h844, 32'h0, s);
    check32("t4_stall6", 32'(s), 32'd6);
    if (txn_log.size() > 0) check32("t4_no_write", 32'(txn_log[0].we), 32'd0);

    // Reset during ALLOCATE.
    lat_cfg = 20;
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'hC40;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("t5_pre_stall", 32'(cpu_stall_o), 32'd1);
    check32("t5_pre_req", 32'(mem_req_o), 32'd1);
    @(posedge clk); #1;
    rst_i = 1'b1; cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 32; i++) m_valid[i] = 0;
    @(negedge clk);
    check32("t5_req", 32'(mem_req_o), 32'd0);
    check32("t5_stall", 32'(cpu_stall_o), 32'd0);
    repeat (2) @(posedge clk);
    lat_cfg = 2;
    do_access(1'b0, 32'h844, 32'h0, s);
    check32("t5_remiss", 32'(s > 0), 32'd1);

    // Stray ack in IDLE must not disturb anything.
    @(posedge clk); #1 idle_ack = 1'b1;
    @(negedge clk);
    check32("t6_stall", 32'(cpu_stall_o), 32'd0);
    @(posedge clk); #1 idle_ack = 1'b0;
    @(negedge clk);
    check32("t6_req", 32'(mem_req_o), 32'd0);
    do_access(1'b0, 32'h844, 32'h0, s);
    check32("t6_hit", 32'(s), 32'd0);

    // Random traffic over 4 tags x 4 indices to force conflicts and evictions.
    for (int n = 0; n < 300; n++) begin
      lat_cfg = int'($urandom_range(1, 4));
      ra = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
      rw = $urandom;
      do_access(1'($urandom_range(0, 1)), ra, rw, s);
    end

    repeat (3) @(posedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
